hazard_ctrl_unit: RTL

- Parametrised pipeline hazard controller for the RV32I core.
- Detects load-use and taken-branch hazards, and generates the per-stage stall, flush and bubble controls.
- Unlike a purely combinational detector, it supports multi-cycle load latency, multi-cycle fetch flush and a data-memory wait freeze, and keeps saturating stall/flush performance counters.
- It sits between ID/EX decode signals and the IF/ID/EX pipeline registers.

---
 rtl/riscv_pkg.sv | 17 +
 rtl/hazard_ctrl_unit_sat_counter.sv | 24 ++
 rtl/hazard_ctrl_unit.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared definitions for the RV32I pipeline control slice.
// Holds the register-index width default, the hazard controller state
// type and the architectural zero-register index.
package riscv_pkg;

  localparam int unsigned NB_OPERAND_DEF = 5;

  // x0 is hard-wired to zero and can never carry a data dependency.
  localparam logic [NB_OPERAND_DEF-1:0] REG_ZERO = '0;

  typedef enum logic [1:0] {
    IDLE,
    LOAD_STALL,
    FLUSH
  } hazard_state_t;

endpackage

// File: rtl/hazard_ctrl_unit_sat_counter.sv
// sat_counter: saturating up-counter used for pipeline performance stats.
// Ports:
//   i_clk  - clock
//   i_rst  - asynchronous active-high reset, clears the count
//   i_en   - count one event this cycle
//   o_cnt  - current count; sticks at all-ones instead of wrapping
module sat_counter #(
  parameter int unsigned NB_CNT = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  output logic [NB_CNT-1:0] o_cnt
);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_cnt <= '0;
    end else if (i_en && (o_cnt != '1)) begin
      o_cnt <= o_cnt + NB_CNT'(1);
    end
  end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// hazard_ctrl_unit: pipeline hazard controller for the RV32I core.
// Detects load-use and taken-branch hazards and drives the IF/ID/EX
// stall, flush and bubble controls. Supports multi-cycle load latency,
// multi-cycle fetch flush and a data-memory wait freeze.
// Ports:
//   i_clk, i_rst                  - clock, asynchronous active-high reset
//   i_ex_is_load, i_ex_rd         - EX-stage load flag and destination
//   i_id_rs1/rs2, i_id_uses_rs1/2 - ID-stage sources and their use flags
//   i_branch_taken                - EX branch/jump resolved taken
//   i_dmem_ready                  - low freezes the whole pipeline
//   o_stall_if, o_stall_id        - hold PC/IF-ID and ID/EX source fields
//   o_bubble_ex                   - insert NOP into ID/EX
//   o_flush_if, o_flush_id        - squash IF/ID and ID/EX
//   o_freeze                      - hold all pipeline registers
//   o_load_hazard, o_branch_hazard- hazard status for this cycle
//   o_load_stall_cnt, o_flush_cnt - saturating performance counters
module hazard_ctrl_unit
  import riscv_pkg::*;
#(
  parameter int unsigned NB_OPERAND   = NB_OPERAND_DEF,
  parameter int unsigned LOAD_LATENCY = 1,
  parameter int unsigned FLUSH_DEPTH  = 1,
  parameter int unsigned NB_CNT       = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_ex_is_load,
  input  logic [NB_OPERAND-1:0] i_ex_rd,
  input  logic [NB_OPERAND-1:0] i_id_rs1,
  input  logic [NB_OPERAND-1:0] i_id_rs2,
  input  logic                  i_id_uses_rs1,
  input  logic                  i_id_uses_rs2,
  input  logic                  i_branch_taken,
  input  logic                  i_dmem_ready,
  output logic                  o_stall_if,
  output logic                  o_stall_id,
  output logic                  o_bubble_ex,
  output logic                  o_flush_if,
  output logic                  o_flush_id,
  output logic                  o_freeze,
  output logic                  o_load_hazard,
  output logic                  o_branch_hazard,
  output logic [NB_CNT-1:0]     o_load_stall_cnt,
  output logic [NB_CNT-1:0]     o_flush_cnt
);

  localparam int unsigned CNT_MAX = (LOAD_LATENCY > FLUSH_DEPTH) ? LOAD_LATENCY : FLUSH_DEPTH;
  localparam int unsigned NB_DCNT = $clog2(CNT_MAX + 1);

  localparam logic [NB_DCNT-1:0] LOAD_RELOAD  = NB_DCNT'(LOAD_LATENCY - 1);
  localparam logic [NB_DCNT-1:0] FLUSH_RELOAD = NB_DCNT'(FLUSH_DEPTH - 1);
  localparam logic [NB_DCNT-1:0] DCNT_ONE     = NB_DCNT'(1);

  hazard_state_t       state, state_n;
  logic [NB_DCNT-1:0]  cnt, cnt_n;
  logic                load_hit;
  logic                inc_load, inc_flush;

  assign load_hit = i_ex_is_load && (i_ex_rd != NB_OPERAND'(REG_ZERO)) &&
                    ((i_id_uses_rs1 && (i_ex_rd == i_id_rs1)) ||
                     (i_id_uses_rs2 && (i_ex_rd == i_id_rs2)));

  // Controls are decoded combinationally from the inputs and the registered
  // state so a hazard is acted on in the same cycle it is seen. Priority is
  // reset > freeze > branch > load; a branch taken in any state restarts the
  // flush sequence and discards any remaining load bubbles.
  always_comb begin
    o_stall_if      = 1'b0;
    o_stall_id      = 1'b0;
    o_bubble_ex     = 1'b0;
    o_flush_if      = 1'b0;
    o_flush_id      = 1'b0;
    o_freeze        = 1'b0;
    o_load_hazard   = 1'b0;
    o_branch_hazard = 1'b0;
    inc_load        = 1'b0;
    inc_flush       = 1'b0;
    state_n         = state;
    cnt_n           = cnt;

    if (i_rst) begin
      state_n = IDLE;
      cnt_n   = '0;
    end else if (!i_dmem_ready) begin
      o_freeze = 1'b1;
    end else if (i_branch_taken) begin
      o_flush_if      = 1'b1;
      o_flush_id      = 1'b1;
      o_branch_hazard = 1'b1;
      inc_flush       = 1'b1;
      if (FLUSH_DEPTH > 1) begin
        state_n = FLUSH;
        cnt_n   = FLUSH_RELOAD;
      end else begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    end else begin
      unique case (state)
        IDLE: begin
          if (load_hit) begin
            o_stall_if    = 1'b1;
            o_stall_id    = 1'b1;
            o_bubble_ex   = 1'b1;
            o_load_hazard = 1'b1;
            inc_load      = 1'b1;
            if (LOAD_LATENCY > 1) begin
              state_n = LOAD_STALL;
              cnt_n   = LOAD_RELOAD;
            end
          end
        end
        LOAD_STALL: begin
          o_stall_if    = 1'b1;
          o_stall_id    = 1'b1;
          o_bubble_ex   = 1'b1;
          o_load_hazard = 1'b1;
          inc_load      = 1'b1;
          if (cnt == DCNT_ONE) begin
            state_n = IDLE;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt - DCNT_ONE;
          end
        end
        FLUSH: begin
          o_flush_if      = 1'b1;
          o_branch_hazard = 1'b1;
          if (cnt == DCNT_ONE) begin
            state_n = IDLE;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt - DCNT_ONE;
          end
        end
        default: begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  sat_counter #(
    .NB_CNT (NB_CNT)
  ) u_load_stall_cnt (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_en  (inc_load),
    .o_cnt (o_load_stall_cnt)
  );

  sat_counter #(
    .NB_CNT (NB_CNT)
  ) u_flush_cnt (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_en  (inc_flush),
    .o_cnt (o_flush_cnt)
  );

endmodule
